ex_mem_skid_reg: RTL

//  Parametrised, elastic successor to the EX/MEM pipeline register. It sits between the
//  EX and MEM stages and carries the MEM-ctrl, WB-ctrl, ALU result, store data (src2) and

---
 rtl/ex_mem_skid_reg_pkg.sv | 21 ++
 rtl/ex_mem_skid_reg_if.sv | 40 ++++
 rtl/pipe_entry_reg.sv | 43 ++++
 rtl/ex_mem_skid_reg.sv | 105 ++++++++++
 4 files changed

// File: rtl/ex_mem_skid_reg_pkg.sv
// rtl/ex_mem_skid_reg_pkg.sv - shared widths, payload layout helper and occupancy encoding for the EX/MEM skid register
package ex_mem_skid_reg_pkg;

  localparam int DEF_WIDTH          = 32;
  localparam int DEF_R_WIDTH        = 5;
  localparam int DEF_MEM_CTRL_WIDTH = 2;
  localparam int DEF_WB_CTRL_WIDTH  = 2;

  // Packed payload order, MSB first: {MEM_ctrl, WB_ctrl, result, src2, rd}
  function automatic int payload_width(input int mem_w, input int wb_w,
                                       input int data_w, input int r_w);
    return mem_w + wb_w + 2 * data_w + r_w;
  endfunction

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/ex_mem_skid_reg_if.sv
// rtl/ex_mem_skid_reg_if.sv - EX-side and MEM-side handshake/payload bundle of the EX/MEM skid register
interface ex_mem_skid_reg_if
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int R_WIDTH        = DEF_R_WIDTH,
  parameter int MEM_CTRL_WIDTH = DEF_MEM_CTRL_WIDTH,
  parameter int WB_CTRL_WIDTH  = DEF_WB_CTRL_WIDTH
) ();

  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [MEM_CTRL_WIDTH-1:0] MEM_ctrl_d;
  logic [WB_CTRL_WIDTH-1:0]  WB_ctrl_d;
  logic [WIDTH-1:0]          result_d;
  logic [WIDTH-1:0]          src2_d;
  logic [R_WIDTH-1:0]        rd_d;

  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [MEM_CTRL_WIDTH-1:0] MEM_ctrl_q;
  logic [WB_CTRL_WIDTH-1:0]  WB_ctrl_q;
  logic [WIDTH-1:0]          result_q;
  logic [WIDTH-1:0]          src2_q;
  logic [R_WIDTH-1:0]        rd_q;
  logic [1:0]                occupancy_o;

  modport master (
    output in_valid_i, MEM_ctrl_d, WB_ctrl_d, result_d, src2_d, rd_d, out_ready_i,
    input  in_ready_o, out_valid_o, MEM_ctrl_q, WB_ctrl_q, result_q, src2_q, rd_q,
           occupancy_o
  );

  modport slave (
    input  in_valid_i, MEM_ctrl_d, WB_ctrl_d, result_d, src2_d, rd_d, out_ready_i,
    output in_ready_o, out_valid_o, MEM_ctrl_q, WB_ctrl_q, result_q, src2_q, rd_q,
           occupancy_o
  );

endinterface

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one pipeline entry: valid bit plus packed payload with load/clear enables
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d,  data_q;

  // Load wins over clear so a drained entry can be refilled on the same edge;
  // clearing only drops valid and leaves the payload stale.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - elastic EX/MEM pipeline register with a one-entry skid buffer and flush
module ex_mem_skid_reg
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int R_WIDTH        = DEF_R_WIDTH,
  parameter int MEM_CTRL_WIDTH = DEF_MEM_CTRL_WIDTH,
  parameter int WB_CTRL_WIDTH  = DEF_WB_CTRL_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 flush_i,
  ex_mem_skid_reg_if.slave     bus
);

  localparam int PW = payload_width(MEM_CTRL_WIDTH, WB_CTRL_WIDTH, WIDTH, R_WIDTH);

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_data_in;
  logic [PW-1:0] main_data;
  logic [PW-1:0] skid_data;
  logic          main_v, skid_v;
  logic          accept, drain;
  logic          main_load, main_clear;
  logic          skid_load, skid_clear;
  occ_e          occ;

  logic [MEM_CTRL_WIDTH-1:0] main_mem_ctrl;
  logic [WB_CTRL_WIDTH-1:0]  main_wb_ctrl;

  assign in_payload = {bus.MEM_ctrl_d, bus.WB_ctrl_d, bus.result_d, bus.src2_d, bus.rd_d};

  // in_ready depends only on the registered skid valid, never on out_ready
  assign accept = bus.in_valid_i & ~skid_v;
  assign drain  = main_v & bus.out_ready_i;

  always_comb begin
    main_load    = 1'b0;
    main_clear   = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    main_data_in = in_payload;
    if (flush_i) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (skid_v) begin
      // Full: only a drain can make progress, and the skid word moves up
      if (drain) begin
        main_load    = 1'b1;
        main_data_in = skid_data;
        skid_clear   = 1'b1;
      end
    end else begin
      if (accept && (!main_v || drain)) begin
        main_load = 1'b1;
      end else if (accept) begin
        skid_load = 1'b1;
      end else if (drain) begin
        main_clear = 1'b1;
      end
    end
  end

  pipe_entry_reg #(.W(PW)) u_main (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_data_in),
    .valid_o (main_v),
    .data_o  (main_data)
  );

  pipe_entry_reg #(.W(PW)) u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (in_payload),
    .valid_o (skid_v),
    .data_o  (skid_data)
  );

  assign {main_mem_ctrl, main_wb_ctrl, bus.result_q, bus.src2_q, bus.rd_q} = main_data;

  // Bubbles present all-zero control so a valid-blind consumer sees a NOP
  assign bus.MEM_ctrl_q  = main_v ? main_mem_ctrl : '0;
  assign bus.WB_ctrl_q   = main_v ? main_wb_ctrl  : '0;
  assign bus.out_valid_o = main_v;
  assign bus.in_ready_o  = ~skid_v;

  always_comb begin
    occ = OCC_ONE;
    unique case ({main_v, skid_v})
      2'b00:   occ = OCC_EMPTY;
      2'b11:   occ = OCC_FULL;
      default: occ = OCC_ONE;
    endcase
  end

  assign bus.occupancy_o = occ;

  skid_implies_main: assert property (@(negedge clk_i) disable iff (!rst_n_i) !(skid_v && !main_v));

endmodule
